// File: rtl/calc_pkg.sv
// Shared types and the sign-magnitude to two's complement encoder for the signed calculator.
package calc_pkg;

    localparam int CALC_W = 3;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    // Negative zero falls out as 0 because ~0 + 1 wraps within CALC_W bits.
    function automatic logic [CALC_W-1:0] sm_to_tc(input logic sign, input logic [CALC_W-2:0] mag);
        logic [CALC_W-1:0] ext;
        ext = {1'b0, mag};
        return sign ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce, registered rising-edge pulse.
// Debounce counter is present only when OPERAND_ENTRY_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync_p0, sync_p1;
    logic lvl, lvl_prev;

    // stage p0/p1: metastability synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          deb;

    // conditioned level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_p1 == deb) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            deb <= sync_p1;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = deb;
`else
    assign lvl = sync_p1;
`endif

    // edge stage: one-cycle pulse per accepted rising level
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            pulse    <= lvl & ~lvl_prev;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: captures A, B and mode from switches and issues them over valid/ready.
// Build option OPERAND_ENTRY_DEBOUNCE_EN adds button debouncing inside btn_conditioner.
module operand_entry
    import calc_pkg::*;
#(
    parameter int W          = CALC_W,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_sign,
    input  logic [W-2:0] sw_mag,
    input  logic         sw_m,
    input  logic         btn_enter,
    input  logic         btn_clear,
    input  logic         op_ready,
    output logic         op_valid,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         op_m,
    output logic [1:0]   state_o
);

    logic enter_pulse, clear_pulse;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_enter),
        .pulse (enter_pulse)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .pulse (clear_pulse)
    );

    state_t              state, state_nxt;
    logic signed [W-1:0] tc;
    logic [W-1:0]        a_nxt, b_nxt;
    logic                m_nxt, valid_nxt;

    assign tc = sm_to_tc(sw_sign, sw_mag);

    // clear outranks both a simultaneous enter and a simultaneous handshake
    always_comb begin
        state_nxt = state;
        a_nxt     = op_a;
        b_nxt     = op_b;
        m_nxt     = op_m;
        valid_nxt = op_valid;
        if (clear_pulse) begin
            state_nxt = S_A;
            a_nxt     = '0;
            b_nxt     = '0;
            m_nxt     = 1'b0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (enter_pulse) begin
                        a_nxt     = tc;
                        state_nxt = S_B;
                    end
                end
                S_B: begin
                    if (enter_pulse) begin
                        b_nxt     = tc;
                        m_nxt     = sw_m;
                        valid_nxt = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_valid && op_ready) begin
                        valid_nxt = 1'b0;
                        state_nxt = S_A;
                    end
                end
                default: begin
                    valid_nxt = 1'b0;
                    state_nxt = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_A;
            op_a     <= '0;
            op_b     <= '0;
            op_m     <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_a     <= a_nxt;
            op_b     <= b_nxt;
            op_m     <= m_nxt;
            op_valid <= valid_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: cycle model compared every cycle plus directed literal checks.
module tb_operand_entry;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sw_sign = 1'b0;
    logic [W-2:0] sw_mag = '0;
    logic         sw_m = 1'b0;
    logic         btn_enter = 1'b0;
    logic         btn_clear = 1'b0;
    logic         op_ready = 1'b0;
    logic         op_valid;
    logic [W-1:0] op_a, op_b;
    logic         op_m;
    logic [1:0]   state_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_entry #(.W(W), .DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_sign   (sw_sign),
        .sw_mag    (sw_mag),
        .sw_m      (sw_m),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .op_ready  (op_ready),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_m      (op_m),
        .state_o   (state_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic s, input logic [W-2:0] mg);
        int v;
        v = s ? -int'(mg) : int'(mg);
        return v[W-1:0];
    endfunction

    // Behavioural model: a button press acts on the 4th edge after the first edge that sees it high.
    logic [3:0]   eh = '0, ch = '0;
    int           m_state = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_m = 1'b0, m_valid = 1'b0;
    int           m_xfers = 0;
    logic         m_init = 1'b0;

    always @(posedge clk) begin
        logic ent, clr;
        ent = eh[2] & ~eh[3];
        clr = ch[2] & ~ch[3];
        if (rst) begin
            eh = '0; ch = '0;
            m_state = 0; m_a = '0; m_b = '0; m_m = 1'b0; m_valid = 1'b0;
            m_init = 1'b1;
        end else begin
            if (clr) begin
                m_state = 0; m_a = '0; m_b = '0; m_m = 1'b0; m_valid = 1'b0;
            end else if (m_state == 0 && ent) begin
                m_a = enc(sw_sign, sw_mag);
                m_state = 1;
            end else if (m_state == 1 && ent) begin
                m_b = enc(sw_sign, sw_mag);
                m_m = sw_m;
                m_valid = 1'b1;
                m_state = 2;
            end else if (m_state == 2 && op_ready) begin
                m_valid = 1'b0;
                m_state = 0;
                m_xfers++;
            end
            eh = {eh[2:0], btn_enter};
            ch = {ch[2:0], btn_clear};
        end
    end

    int   vcnt = 0;
    int   sb_entries = 0;
    logic [1:0] prev_st = 2'd0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("op_valid", int'(op_valid), int'(m_valid));
            chk("op_a", int'(op_a), int'(m_a));
            chk("op_b", int'(op_b), int'(m_b));
            chk("op_m", int'(op_m), int'(m_m));
            chk("state_o", int'(state_o), m_state);
        end
        if (op_valid) vcnt++;
        if (state_o == 2'd1 && prev_st == 2'd0) sb_entries++;
        prev_st = state_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic s, input logic [W-2:0] mg);
        sw_sign = s;
        sw_mag = mg;
        btn_enter = 1'b1;
        tick(); tick();
        btn_enter = 1'b0;
        repeat (4) tick();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick(); tick();
        btn_clear = 1'b0;
        repeat (4) tick();
    endtask

    logic         tab_s [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-2:0] tab_m [3] = '{2'd3, 2'd1, 2'd2};
    logic [W-1:0] tab_e [3] = '{3'b011, 3'b111, 3'b110};

    initial begin
        int v0, s0;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset op_valid", int'(op_valid), 0);
        chk("reset op_a", int'(op_a), 0);
        chk("reset op_b", int'(op_b), 0);
        chk("reset op_m", int'(op_m), 0);
        chk("reset state_o", int'(state_o), 0);
        rst = 1'b0;
        tick();

        // +2 then -3, subtract, datapath ready
        sw_m = 1'b1;
        op_ready = 1'b1;
        v0 = vcnt;
        press_enter(1'b0, 2'd2);
        press_enter(1'b1, 2'd3);
        @(negedge clk);
        chk("s1 op_a", int'(op_a), 3'b010);
        chk("s1 op_b", int'(op_b), 3'b101);
        chk("s1 op_m", int'(op_m), 1);
        chk("s1 state_o", int'(state_o), 0);
        chk("s1 valid cycles", vcnt - v0, 1);
        chk("s1 xfers", m_xfers, 1);

        // same entries, datapath stalls 10 cycles
        tick();
        op_ready = 1'b0;
        v0 = vcnt;
        press_enter(1'b0, 2'd2);
        press_enter(1'b1, 2'd3);
        repeat (10) tick();
        @(negedge clk);
        chk("s2 stalled valid", int'(op_valid), 1);
        chk("s2 stalled op_a", int'(op_a), 3'b010);
        chk("s2 stalled op_b", int'(op_b), 3'b101);
        op_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("s2 state_o", int'(state_o), 0);
        chk("s2 valid cycles", vcnt - v0, 13);
        chk("s2 xfers", m_xfers, 2);

        // negative zero for A, then clear colliding with a handshake
        tick();
        op_ready = 1'b0;
        press_enter(1'b1, 2'd0);
        @(negedge clk);
        chk("negzero op_a", int'(op_a), 0);
        chk("negzero state_o", int'(state_o), 1);
        tick();
        press_enter(1'b0, 2'd1);
        btn_clear = 1'b1;
        tick(); tick();
        btn_clear = 1'b0;
        tick();
        op_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("clr op_valid", int'(op_valid), 0);
        chk("clr state_o", int'(state_o), 0);
        chk("clr op_a", int'(op_a), 0);
        chk("clr op_b", int'(op_b), 0);
        chk("clr xfers", m_xfers, 2);

        // enter held for 20 cycles gives a single step
        tick();
        op_ready = 1'b0;
        s0 = sb_entries;
        sw_sign = 1'b0;
        sw_mag = 2'd1;
        btn_enter = 1'b1;
        repeat (20) tick();
        btn_enter = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("hold state_o", int'(state_o), 1);
        chk("hold entries", sb_entries - s0, 1);
        chk("hold op_a", int'(op_a), 1);
        tick();
        press_clear();

        // encoder corner values on A
        for (int i = 0; i < 3; i++) begin
            press_enter(tab_s[i], tab_m[i]);
            @(negedge clk);
            chk("enc op_a", int'(op_a), int'(tab_e[i]));
            tick();
            press_clear();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Input-side front end of the signed calculator.
- Captures operands A and B from switches as sign-magnitude entries, one per button press, along with the add/sub mode.
- Encodes each operand to two's complement and hands the pair to the add/sub datapath over a valid/ready handshake.
- It is the encoder counterpart of the result path, which converts two's complement back to sign-magnitude for display.

Parameters:
- W, 3, operand width in bits (two's complement); the magnitude field is W-1 bits.
- DEB_CYCLES, 4, number of cycles a button level must be stable before it is accepted (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sw_sign  input  1  sign of the entry (1 = negative).
- sw_mag  input  W-1  magnitude of the entry.
- sw_m  input  1  mode select (0 = add, 1 = subtract).
- btn_enter  input  1  asynchronous push button; commits the current entry.
- btn_clear  input  1  asynchronous push button; aborts entry.
- op_ready  input  1  datapath accepts the operands.
- op_valid  output  1  operands are presented.
- op_a  output  W  operand A, two's complement.
- op_b  output  W  operand B, two's complement.
- op_m  output  1  latched mode.
- state_o  output  2  current state, for LEDs: 0 = S_A, 1 = S_B, 2 = S_ISSUE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. With rst high at a clk edge, all outputs go to 0, the state goes to S_A, and synchronizers and edge detectors are cleared.
- Button conditioning: each button passes through a 2-flop synchronizer, then a rising-edge detector (1 cycle). An edge pulse is 1 cycle wide, 3 cycles after the button rises. Holding the button produces no further pulses.
- Encoding: tc = sw_sign ? (~{1'b0, sw_mag} + 1) : {1'b0, sw_mag}, truncated to W bits.
  - Range for W=3 is -3..+3.
  - Negative zero (sign=1, mag=0) encodes to 0.
  - -4 cannot be entered.
- State machine:
  - S_A: an enter pulse latches op_a = tc, then moves to S_B.
  - S_B: an enter pulse latches op_b = tc and op_m = sw_m, then moves to S_ISSUE.
  - S_ISSUE: op_valid = 1, and op_a, op_b and op_m are held stable. When op_valid && op_ready at a clk edge, the next state is S_A and op_valid falls in the same edge's update. Enter pulses are ignored.
- Register updates occur on the clk edge that sees the pulse. op_valid rises on the edge that enters S_ISSUE, so it is valid 4 cycles after btn_enter rises.
- op_ready is ignored outside S_ISSUE.
- Clear pulse from any state:
  - Next state is S_A and op_valid goes to 0.
  - op_a, op_b and op_m are zeroed.
  - Clear wins over a simultaneous enter pulse and over a simultaneous op_ready handshake; that handshake is not counted as accepted.
- op_a and op_b keep their values after a handshake until overwritten or cleared.
- Reset asserted mid-operation: the rst branch has priority over every other action.
- Switch inputs are static user levels: sampled directly at the enter pulse, not synchronized.

Optional Feature:
- Macro: OPERAND_ENTRY_DEBOUNCE_EN.
- Defined: a per-button counter follows the synchronizer. The conditioned level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles, and the edge detector runs on the conditioned level. Enter-to-action latency increases by DEB_CYCLES. Glitches shorter than DEB_CYCLES produce no pulse.
- Not defined: there is no counter; the edge detector runs on the synchronized level, and every clean rising edge produces a pulse.

Decomposition:
- Package calc_pkg holds:
  - default width constant CALC_W = 3;
  - state typedef enum (S_A, S_B, S_ISSUE), 2 bits;
  - function sm_to_tc(sign, mag), the encoder above.
- One sub-module, btn_conditioner: synchronizer, optional debounce, rising-edge pulse. Instantiated once for btn_enter and once for btn_clear.

Test Plan:
- Reset: hold rst 2 cycles -> op_valid = 0, op_a = op_b = 0, op_m = 0, state_o = 0.
- Enter +2 (sign 0, mag 2), then -3 (sign 1, mag 3) with sw_m = 1, op_ready = 1 -> op_a = 3'b010, op_b = 3'b101, op_m = 1. op_valid is high for exactly 1 cycle, then state_o = 0.
- Same entries with op_ready = 0 for 10 cycles, then 1 -> op_valid high 10+ cycles, data stable throughout, single transfer.
- Negative zero (sign 1, mag 0) for A -> op_a = 3'b000.
- In S_ISSUE, pulse btn_clear in the same cycle as op_ready = 1 -> no transfer counted, op_valid = 0, state_o = 0, op_a = 0.
- Hold btn_enter high 20 cycles in S_A -> exactly one transition to S_B. With OPERAND_ENTRY_DEBOUNCE_EN, a 2-cycle glitch gives no transition.
